// File: rtl/pc_sequencer_pkg.sv
// Shared state encodings and step constants for the PC sequencer.
// Imported by the sequencer top and its sub-modules.
package pc_sequencer_pkg;

  localparam logic [1:0] ST_HOLD  = 2'b00;
  localparam logic [1:0] ST_FETCH = 2'b01;
  localparam logic [1:0] ST_EXEC  = 2'b10;

  localparam int unsigned INC_ONE = 1;
  localparam int unsigned INC_TWO = 2;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Ripple incrementer: pc+1 or pc+2 (skip), plus pc+1 link path.
// Carry out of the top bit is dropped so addresses wrap.
module pc_adder
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             skip,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] link
);

  function automatic logic [WIDTH-1:0] ripple(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] s;
    logic             c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  logic [WIDTH-1:0] step;

  assign step = skip ? WIDTH'(INC_TWO) : WIDTH'(INC_ONE);
  assign sum  = ripple(a, step);
  assign link = ripple(a, WIDTH'(INC_ONE));

endmodule

// File: rtl/pc_sequencer_reg.sv
// Edge-triggered register with async active-low clear.
// Holds either the PC or the FSM state.
module pc_sequencer_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nclr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-fetch-address sequencer with HOLD/FETCH/EXEC handshake.
// PC only moves on the EXEC->FETCH edge: jump, else skip, else +1.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             stall,
  input  logic             jump,
  input  logic [WIDTH-1:0] target,
  input  logic             skip,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic             exec,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link_pc
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_step;

  pc_sequencer_reg #(.W(WIDTH)) u_pc_reg (
    .clk (clk),
    .nclr(nclr),
    .en  (1'b1),
    .d   (pc_d),
    .q   (pc_q)
  );

  pc_sequencer_reg #(.W(2)) u_st_reg (
    .clk (clk),
    .nclr(nclr),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_q)
  );

  pc_adder #(.WIDTH(WIDTH)) u_add (
    .a   (pc_q),
    .skip(skip),
    .sum (pc_step),
    .link(link_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (1'b1)
      state_q == ST_HOLD: begin
        state_d = ST_FETCH;
      end
      state_q == ST_FETCH: begin
        if (fetch_ready) state_d = ST_EXEC;
      end
      state_q == ST_EXEC: begin
        if (!stall) begin
          state_d = ST_FETCH;
          pc_d    = jump ? target : pc_step;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  assign fetch_valid = (state_q == ST_FETCH);
  assign exec        = (state_q == ST_EXEC);
  assign pc          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random
// traffic, checked against an instruction-level reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       nclr;
  logic       stall;
  logic       jump;
  logic [7:0] target;
  logic       skip;
  logic       fetch_ready;
  logic       fetch_valid;
  logic       exec;
  logic [7:0] pc;
  logic [7:0] link_pc;

  pc_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .nclr       (nclr),
    .stall      (stall),
    .jump       (jump),
    .target     (target),
    .skip       (skip),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .exec       (exec),
    .pc         (pc),
    .link_pc    (link_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fv;
    bit ex;
    int pcv;
    int link;
  } exp_t;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_EXE  = 2;

  exp_t q[$];
  int   m_phase;
  int   m_pc;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  function automatic exp_t snap();
    exp_t e;
    e.fv   = (m_phase == P_REQ);
    e.ex   = (m_phase == P_EXE);
    e.pcv  = m_pc;
    e.link = (m_pc + 1) % 256;
    return e;
  endfunction

  // One instruction-level step of the reference: what happens at the next edge.
  function automatic void model_step(bit s, bit j, bit sk, int tg, bit rdy);
    case (m_phase)
      P_IDLE: m_phase = P_REQ;
      P_REQ:  if (rdy) m_phase = P_EXE;
      default: begin
        if (!s) begin
          m_pc    = j ? tg : (m_pc + (sk ? 2 : 1)) % 256;
          m_phase = P_REQ;
        end
      end
    endcase
  endfunction

  task automatic drive(bit s, bit j, bit sk, logic [7:0] tg, bit rdy);
    @(posedge clk);
    #2;
    nclr        = 1'b1;
    stall       = s;
    jump        = j;
    skip        = sk;
    target      = tg;
    fetch_ready = rdy;
    model_step(s, j, sk, int'(tg), rdy);
    q.push_back(snap());
  endtask

  task automatic to_exec();
    int n = 0;
    while (m_phase != P_EXE && n < 10) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n++;
    end
  endtask

  task automatic goto_addr(logic [7:0] a);
    to_exec();
    drive(1'b0, 1'b1, 1'b0, a, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // Called between edges; pulses nclr and checks the immediate effect.
  task automatic async_clear();
    nclr = 1'b0;
    #1;
    n_tests++;
    if (pc !== 8'h00 || fetch_valid !== 1'b0 || exec !== 1'b0 ||
        link_pc !== 8'h01) begin
      n_fail++;
      $display("FAIL async_rst: pc=%h fv=%b ex=%b link=%h want pc=00 fv=0 ex=0 link=01",
               pc, fetch_valid, exec, link_pc);
    end
    #1;
    nclr        = 1'b1;
    stall       = 1'b0;
    jump        = 1'b0;
    skip        = 1'b0;
    fetch_ready = 1'b0;
    m_phase     = P_IDLE;
    m_pc        = 0;
    q.delete();
    q.push_back(snap());
    model_step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    q.push_back(snap());
  endtask

  always @(negedge clk) begin
    if (!done) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (fetch_valid !== e.fv || exec !== e.ex ||
            pc !== e.pcv[7:0] || link_pc !== e.link[7:0]) begin
          n_fail++;
          $display("FAIL cycle@%0t: fv=%b ex=%b pc=%h link=%h want fv=%b ex=%b pc=%h link=%h",
                   $time, fetch_valid, exec, pc, link_pc,
                   e.fv, e.ex, e.pcv[7:0], e.link[7:0]);
        end
      end
    end
  end

  initial begin
    nclr        = 1'b0;
    stall       = 1'b0;
    jump        = 1'b0;
    skip        = 1'b0;
    target      = 8'h00;
    fetch_ready = 1'b0;
    m_phase     = P_IDLE;
    m_pc        = 0;
    q.push_back(snap());

    // straight-line fetch/exec from reset
    repeat (8) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // stall holds EXEC at 0x10
    goto_addr(8'h10);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // jump beats skip
    goto_addr(8'h20);
    drive(1'b0, 1'b1, 1'b1, 8'h80, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // wrap cases
    goto_addr(8'hFF);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    goto_addr(8'hFE);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    goto_addr(8'hFF);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

    // fetch wait states
    to_exec();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (5) drive(1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // async clear mid-FETCH at 0x42
    goto_addr(8'h41);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    n_tests++;
    if (pc !== 8'h42 || fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: pc=%h fv=%b want pc=42 fv=1", pc, fetch_valid);
    end
    async_clear();
    repeat (4) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #2;
        async_clear();
      end else begin
        drive($urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0,
              8'($urandom_range(0, 255)),
              $urandom_range(0, 4) < 3);
      end
    end

    begin
      int n = 0;
      while (q.size() > 0 && n < 5) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    done = 1'b1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
